rnn_seq_engine: RTL and testbench

- Parametrised successor to the fixed 2-input/4-hidden RNN accelerator.
- Runs one Elman RNN time step per start command: h' = act(Wx^T·x + Wh^T·h + b), followed by a dense readout y = d·h' + db.
- Uses a single time-shared signed MAC, a shadow hidden buffer (so each step reads only old h), runtime-selectable activation, saturation and a step counter.
- Sits behind the same memory-mapped read/write/addr/data bus as the existing accelerator.

---
 rtl/rnn_seq_engine_if.sv | 14 +
 rtl/rnn_seq_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_rnn_seq_engine.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rnn_seq_engine_if.sv
// Memory-mapped register bus of rnn_seq_engine: strobes, address, write data,
// registered read data and the two status lines.
interface rnn_seq_engine_if;
   logic        read;
   logic        write;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   modport master (output read, write, addr, data_in, input data_out, busy, done);
   modport slave  (input read, write, addr, data_in, output data_out, busy, done);
endinterface

// File: rtl/rnn_seq_engine.sv
// One Elman RNN time step per start command, h' = act(Wx^T x + Wh^T h + b),
// then a dense readout y = d.h' + db, all on a single time-shared signed MAC.
module rnn_seq_engine #(
   parameter int IN_LEN    = 4,
   parameter int HID_LEN   = 8,
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 40
) (
   input  logic            clk,
   input  logic            rst_n,
   rnn_seq_engine_if.slave bus
);
   localparam int XI_W = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
   localparam int HI_W = (HID_LEN > 1) ? $clog2(HID_LEN) : 1;
   localparam logic [XI_W-1:0] X_LAST = XI_W'(IN_LEN - 1);
   localparam logic [HI_W-1:0] H_LAST = HI_W'(HID_LEN - 1);

   typedef logic signed [DATA_W-1:0]   elem_t;
   typedef logic signed [ACC_W-1:0]    acc_t;
   typedef logic signed [2*DATA_W-1:0] prod_t;

   typedef enum logic [2:0] {
      S_IDLE, S_MAC_X, S_MAC_H, S_WB, S_COMMIT, S_DENSE, S_DENSE_WB
   } state_e;

   localparam acc_t  SAT_MAX = acc_t'({1'b0, {(DATA_W-1){1'b1}}});
   localparam acc_t  SAT_MIN = ~SAT_MAX;
   localparam elem_t ONE     = elem_t'(1 << FRAC_BITS);
   localparam elem_t NEG_ONE = -ONE;

   function automatic acc_t bias_acc(elem_t v);
      return acc_t'(v) <<< FRAC_BITS;
   endfunction

   function automatic elem_t shift_sat(acc_t a);
      acc_t s;
      s = a >>> FRAC_BITS;
      if (s > SAT_MAX)      return elem_t'(SAT_MAX);
      else if (s < SAT_MIN) return elem_t'(SAT_MIN);
      else                  return elem_t'(s);
   endfunction

   // Mode 3 deliberately falls through to identity, same as mode 0.
   function automatic elem_t activate(elem_t v, logic [1:0] mode);
      case (mode)
         2'd1:    return v[DATA_W-1] ? '0 : v;
         2'd2: begin
            if (v > ONE)          return ONE;
            else if (v < NEG_ONE) return NEG_ONE;
            else                  return v;
         end
         default: return v;
      endcase
   endfunction

   state_e          state_q;
   logic            busy_q, done_q;
   logic [31:0]     data_out_q;
   logic [1:0]      act_mode_q;
   logic [15:0]     step_count_q;
   logic [7:0]      rd_idx_q;
   logic [XI_W-1:0] i_q;
   logic [HI_W-1:0] j_q, k_q;
   acc_t            acc_q;
   elem_t           y_q, db_q;
   elem_t           x_q      [IN_LEN];
   elem_t           wx_q     [IN_LEN][HID_LEN];
   elem_t           wh_q     [HID_LEN][HID_LEN];
   elem_t           b_q      [HID_LEN];
   elem_t           d_q      [HID_LEN];
   elem_t           h_q      [HID_LEN];
   elem_t           h_next_q [HID_LEN];

   elem_t       op_a_d, op_b_d;
   prod_t       prod_d;
   acc_t        acc_sum_d;
   logic [31:0] rd_data_d;

   logic [7:0] wr_row, wr_col;
   elem_t      wr_val;
   logic       row_in_x, row_in_h, col_in_x, col_in_h, rd_in_h;

   assign wr_row   = bus.data_in[31:24];
   assign wr_col   = bus.data_in[23:16];
   assign wr_val   = elem_t'(bus.data_in[15:0]);
   assign row_in_x = 32'(wr_row) < IN_LEN;
   assign row_in_h = 32'(wr_row) < HID_LEN;
   assign col_in_x = 32'(wr_col) < IN_LEN;
   assign col_in_h = 32'(wr_col) < HID_LEN;
   assign rd_in_h  = 32'(rd_idx_q) < HID_LEN;

   // MAC_H multiplies the committed h, never h_next, so every column sees old state.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      op_a_d = '0;
      op_b_d = '0;
      case (state_q)
         S_MAC_X: begin op_a_d = x_q[i_q]; op_b_d = wx_q[i_q][j_q]; end
         S_MAC_H: begin op_a_d = h_q[k_q]; op_b_d = wh_q[k_q][j_q]; end
         S_DENSE: begin op_a_d = h_q[k_q]; op_b_d = d_q[k_q];       end
         default: ;
      endcase
      prod_d    = prod_t'(op_a_d) * prod_t'(op_b_d);
      acc_sum_d = acc_q + acc_t'(prod_d);
   end

   always_comb begin
      rd_data_d = '0;
      case (bus.addr)
         32'd0:  rd_data_d = {30'b0, done_q, busy_q};
         32'd8:  if (rd_in_h) rd_data_d = 32'(h_q[rd_idx_q[HI_W-1:0]]);
         32'd9:  rd_data_d = {16'b0, step_count_q};
         32'd10: rd_data_d = 32'(y_q);
         default: ;
      endcase
   end

   assign bus.data_out = data_out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         data_out_q   <= '0;
         act_mode_q   <= '0;
         step_count_q <= '0;
         rd_idx_q     <= '0;
         i_q          <= '0;
         j_q          <= '0;
         k_q          <= '0;
         acc_q        <= '0;
         y_q          <= '0;
         db_q         <= '0;
         // NOTE: the register files are reset too, because a reset must also wipe the loaded weights.
         for (int r = 0; r < IN_LEN; r++) begin
            x_q[r] <= '0;
            for (int c = 0; c < HID_LEN; c++) wx_q[r][c] <= '0;
         end
         for (int r = 0; r < HID_LEN; r++) begin
            b_q[r]      <= '0;
            d_q[r]      <= '0;
            h_q[r]      <= '0;
            h_next_q[r] <= '0;
            for (int c = 0; c < HID_LEN; c++) wh_q[r][c] <= '0;
         end
      end else begin
         // NOTE: non-blocking updates make a same-cycle read return the pre-write value.
         if (bus.read) data_out_q <= rd_data_d;

         if (bus.write) begin
            case (bus.addr)
               32'd0: if (!busy_q) begin
                  if (bus.data_in[0]) begin
                     state_q <= S_MAC_X;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                     i_q     <= '0;
                     j_q     <= '0;
                     k_q     <= '0;
                     acc_q   <= bias_acc(b_q[0]);
                     if (bus.data_in[1])
                        for (int r = 0; r < HID_LEN; r++) h_q[r] <= '0;
                  end else if (bus.data_in[2]) begin
                     for (int r = 0; r < HID_LEN; r++) h_q[r] <= '0;
                  end
               end
               32'd1: if (!busy_q && col_in_x) x_q[wr_col[XI_W-1:0]] <= wr_val;
               32'd2: if (!busy_q && row_in_x && col_in_h)
                         wx_q[wr_row[XI_W-1:0]][wr_col[HI_W-1:0]] <= wr_val;
               32'd3: if (!busy_q && row_in_h && col_in_h)
                         wh_q[wr_row[HI_W-1:0]][wr_col[HI_W-1:0]] <= wr_val;
               32'd4: if (!busy_q && col_in_h) b_q[wr_col[HI_W-1:0]] <= wr_val;
               32'd5: if (!busy_q && col_in_h) d_q[wr_col[HI_W-1:0]] <= wr_val;
               32'd6: if (!busy_q) db_q <= wr_val;
               32'd7: if (!busy_q) act_mode_q <= bus.data_in[1:0];
               32'd8: rd_idx_q <= wr_col;
               default: ;
            endcase
         end

         case (state_q)
            S_MAC_X: begin
               acc_q <= acc_sum_d;
               if (i_q == X_LAST) begin
                  i_q     <= '0;
                  k_q     <= '0;
                  state_q <= S_MAC_H;
               end else begin
                  i_q <= i_q + XI_W'(1);
               end
            end
            S_MAC_H: begin
               acc_q <= acc_sum_d;
               if (k_q == H_LAST) begin
                  k_q     <= '0;
                  state_q <= S_WB;
               end else begin
                  k_q <= k_q + HI_W'(1);
               end
            end
            S_WB: begin
               h_next_q[j_q] <= activate(shift_sat(acc_q), act_mode_q);
               if (j_q == H_LAST) begin
                  state_q <= S_COMMIT;
               end else begin
                  j_q     <= j_q + HI_W'(1);
                  acc_q   <= bias_acc(b_q[j_q + HI_W'(1)]);
                  state_q <= S_MAC_X;
               end
            end
            S_COMMIT: begin
               for (int r = 0; r < HID_LEN; r++) h_q[r] <= h_next_q[r];
               acc_q   <= bias_acc(db_q);
               k_q     <= '0;
               state_q <= S_DENSE;
            end
            S_DENSE: begin
               acc_q <= acc_sum_d;
               if (k_q == H_LAST) begin
                  k_q     <= '0;
                  state_q <= S_DENSE_WB;
               end else begin
                  k_q <= k_q + HI_W'(1);
               end
            end
            S_DENSE_WB: begin
               y_q          <= shift_sat(acc_q);
               step_count_q <= step_count_q + 16'd1;
               done_q       <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rnn_seq_engine.sv
// Self-checking bench for rnn_seq_engine: table-driven register reads through a
// scoreboard queue plus hand-written sequences for the multi-cycle corner cases.
module tb_rnn_seq_engine;
   localparam int IN_LEN  = 4;
   localparam int HID_LEN = 8;
   localparam int N_BUSY  = HID_LEN * (IN_LEN + HID_LEN + 1) + HID_LEN + 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rnn_seq_engine_if bus_if ();

   rnn_seq_engine #(
      .IN_LEN(IN_LEN), .HID_LEN(HID_LEN), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   int          n_cmp  = 0;
   int          n_fail = 0;
   int unsigned cyc    = 0;
   int unsigned t_start;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  idx;
      logic [31:0] exp;
      string       name;
   } vec_t;

   typedef struct {
      logic [1:0]  act;
      logic [15:0] h0;
      logic [15:0] h1;
   } sat_t;

   function automatic logic [31:0] pack(input logic [7:0] row, input logic [7:0] col,
                                        input logic [15:0] val);
      return {row, col, val};
   endfunction

   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      bus_if.write   = 1'b1;
      bus_if.addr    = a;
      bus_if.data_in = d;
      @(posedge clk); #1;
      bus_if.write   = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, input string name, input logic [31:0] exp);
      sb_t e;
      sb_q.push_back('{name: name, exp: exp});
      bus_if.read = 1'b1;
      bus_if.addr = a;
      @(posedge clk); #1;
      bus_if.read = 1'b0;
      e = sb_q.pop_front();
      check(e.name, bus_if.data_out, e.exp);
   endtask

   task automatic read_h(input int j, input string name, input logic [15:0] exp);
      bus_wr(32'd8, pack(8'd0, 8'(j), 16'd0));
      bus_rd(32'd8, name, sx(exp));
   endtask

   task automatic do_reset();
      bus_if.read    = 1'b0;
      bus_if.write   = 1'b0;
      bus_if.addr    = '0;
      bus_if.data_in = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic start_step(input logic [31:0] ctrl);
      bus_wr(32'd0, ctrl);
      t_start = cyc;
   endtask

   task automatic wait_step(input string name);
      int guard = 0;
      while (bus_if.busy && guard < 1000) begin
         @(posedge clk); #1;
         guard++;
      end
      check({name, " busy cycles"}, cyc - t_start, N_BUSY);
   endtask

   task automatic bias_cfg();
      for (int j = 0; j < HID_LEN; j++) bus_wr(32'd4, pack(8'd0, 8'(j), 16'(j * 256)));
      bus_wr(32'd6, pack(8'd0, 8'd0, 16'h0080));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[13];
      sat_t st[3];

      for (int j = 0; j < HID_LEN; j++)
         vt[j] = '{32'd8, 8'(j), sx(16'(j * 256)), $sformatf("bias h[%0d]", j)};
      vt[8]  = '{32'd10, 8'd0,   32'h0000_0080, "bias y"};
      vt[9]  = '{32'd9,  8'd0,   32'h0000_0001, "bias step_count"};
      vt[10] = '{32'd0,  8'd0,   32'h0000_0002, "bias status"};
      vt[11] = '{32'd8,  8'd200, 32'h0000_0000, "h out of range"};
      vt[12] = '{32'd11, 8'd0,   32'h0000_0000, "unmapped addr"};

      st[0] = '{2'd0, 16'h7FFF, 16'h8000};
      st[1] = '{2'd2, 16'h0100, 16'hFF00};
      st[2] = '{2'd1, 16'h7FFF, 16'h0000};

      do_reset();
      bus_rd(32'd0, "reset status", 32'h0);
      bus_rd(32'd9, "reset step_count", 32'h0);
      bus_rd(32'd10, "reset y", 32'h0);

      // Bias only
      bias_cfg();
      start_step(32'h1);
      check("busy after start", {31'b0, bus_if.busy}, 32'h1);
      bus_rd(32'd0, "status while busy", 32'h1);
      wait_step("bias");
      for (int v = 0; v < 13; v++) begin
         if (vt[v].addr == 32'd8) bus_wr(32'd8, pack(8'd0, vt[v].idx, 16'd0));
         bus_rd(vt[v].addr, vt[v].name, vt[v].exp);
      end

      // Saturation and activation modes
      do_reset();
      bus_wr(32'd1, pack(8'd0, 8'd0, 16'h7FFF));
      bus_wr(32'd2, pack(8'd0, 8'd0, 16'h7FFF));
      bus_wr(32'd2, pack(8'd0, 8'd1, 16'h8001));
      bus_wr(32'd2, pack(8'd9, 8'd0, 16'h0100));
      for (int s = 0; s < 3; s++) begin
         bus_wr(32'd7, {30'b0, st[s].act});
         start_step(32'h1);
         wait_step($sformatf("sat act%0d", st[s].act));
         read_h(0, $sformatf("sat act%0d h0", st[s].act), st[s].h0);
         read_h(1, $sformatf("sat act%0d h1", st[s].act), st[s].h1);
      end

      // Shadow hidden state
      do_reset();
      for (int j = 0; j < HID_LEN; j++) bus_wr(32'd4, pack(8'd0, 8'(j), 16'h0080));
      start_step(32'h1);
      wait_step("shadow s1");
      read_h(0, "shadow s1 h0", 16'h0080);
      read_h(1, "shadow s1 h1", 16'h0080);
      for (int j = 0; j < HID_LEN; j++) bus_wr(32'd4, pack(8'd0, 8'(j), 16'h0000));
      bus_wr(32'd3, pack(8'd0, 8'd1, 16'h0100));
      bus_wr(32'd3, pack(8'd1, 8'd0, 16'h0100));
      start_step(32'h1);
      wait_step("shadow s2");
      read_h(0, "shadow s2 h0", 16'h0080);
      read_h(1, "shadow s2 h1", 16'h0080);
      read_h(2, "shadow s2 h2", 16'h0000);
      bus_wr(32'd4, pack(8'd0, 8'd0, 16'h0100));
      bus_wr(32'd5, pack(8'd0, 8'd0, 16'h0100));
      bus_wr(32'd5, pack(8'd0, 8'd1, 16'h0200));
      bus_wr(32'd6, pack(8'd0, 8'd0, 16'h0010));
      start_step(32'h1);
      wait_step("shadow s3");
      read_h(0, "shadow s3 h0", 16'h0180);
      read_h(1, "shadow s3 h1", 16'h0080);
      bus_rd(32'd10, "shadow s3 y", 32'h0000_0290);

      // Busy protection
      do_reset();
      bias_cfg();
      bus_wr(32'd1, pack(8'd0, 8'd0, 16'h0100));
      start_step(32'h1);
      while (cyc - t_start < 10) begin @(posedge clk); #1; end
      bus_wr(32'd2, pack(8'd0, 8'd7, 16'h0100));
      bus_wr(32'd0, 32'h1);
      bus_wr(32'd4, pack(8'd0, 8'd7, 16'h0000));
      wait_step("protect");
      bus_rd(32'd9, "protect step_count", 32'h1);
      read_h(7, "protect h7", 16'h0700);
      start_step(32'h1);
      wait_step("protect rerun");
      bus_rd(32'd9, "protect rerun step_count", 32'h2);
      read_h(7, "protect rerun h7", 16'h0700);
      read_h(0, "protect rerun h0", 16'h0000);

      // Reset mid-step
      do_reset();
      bias_cfg();
      start_step(32'h1);
      while (cyc - t_start < 50) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrst busy", {31'b0, bus_if.busy}, 32'h0);
      check("midrst done", {31'b0, bus_if.done}, 32'h0);
      check("midrst data_out", bus_if.data_out, 32'h0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      bus_rd(32'd0, "midrst status", 32'h0);
      read_h(3, "midrst h3", 16'h0000);
      bus_rd(32'd9, "midrst step_count", 32'h0);
      bus_rd(32'd10, "midrst y", 32'h0);
      start_step(32'h1);
      wait_step("midrst rerun");
      read_h(3, "midrst rerun h3 (bias lost)", 16'h0000);
      bus_rd(32'd10, "midrst rerun y", 32'h0);

      // Clear hidden
      do_reset();
      bias_cfg();
      start_step(32'h1);
      wait_step("clear s1");
      read_h(5, "clear s1 h5", 16'h0500);
      bus_wr(32'd0, 32'h4);
      check("clear no busy", {31'b0, bus_if.busy}, 32'h0);
      read_h(5, "clear h5", 16'h0000);
      read_h(7, "clear h7", 16'h0000);
      bus_rd(32'd9, "clear step_count", 32'h1);
      bus_rd(32'd0, "clear status", 32'h2);
      start_step(32'h1);
      wait_step("clear s2");
      read_h(1, "clear s2 h1", 16'h0100);
      for (int j = 0; j < HID_LEN; j++) bus_wr(32'd4, pack(8'd0, 8'(j), 16'h0000));
      bus_wr(32'd3, pack(8'd1, 8'd1, 16'h0100));
      bus_wr(32'd3, pack(8'd5, 8'd5, 16'h0100));
      start_step(32'h3);
      wait_step("clear s3");
      read_h(1, "zero-start h1", 16'h0000);
      read_h(5, "zero-start h5", 16'h0000);
      bus_rd(32'd9, "zero-start step_count", 32'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
